// File: rtl/instr_fetch.sv
// instr_fetch: program counter and fetch stage feeding the opcode decode LUT.
// Rev 1.0 - initial release.
`default_nettype none

module instr_fetch #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [PC_W-1:0]    i_start_addr,
  input  logic               i_stall,
  input  logic               i_branch_abs,
  input  logic               i_branch_rel,
  input  logic [PC_W-1:0]    i_target,
  input  logic               i_halt,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic [PC_W-1:0]    o_prog_ctr,
  output logic [INSTR_W-1:0] o_instr_q,
  output logic [PC_W-1:0]    o_instr_pc,
  output logic [5:0]         o_op_addr,
  output logic               o_instr_valid,
  output logic               o_running,
  output logic               o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr_q, w_instr_q_nxt;
  logic [PC_W-1:0]    r_instr_pc, w_instr_pc_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_running, r_done;
  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_rel_target;

  assign w_pc_inc     = r_pc + PC_W'(1);
  assign w_rel_target = r_instr_pc + i_target;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_q_nxt  = r_instr_q;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = i_start_addr;
          w_valid_nxt = 1'b0;
        end
      end
      S_RUN: begin
        // Redirect/halt only act on a live instruction; a bubble falls through to fetch.
        if (i_stall) begin
          w_state_nxt = r_state;
        end else if (i_halt && r_valid) begin
          w_state_nxt = S_HALTED;
          w_valid_nxt = 1'b0;
        end else if (i_branch_abs && r_valid) begin
          w_pc_nxt    = i_target;
          w_valid_nxt = 1'b0;
        end else if (i_branch_rel && r_valid) begin
          w_pc_nxt    = w_rel_target;
          w_valid_nxt = 1'b0;
        end else begin
          w_instr_q_nxt  = i_imem_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = w_pc_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr_q  <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr_q  <= w_instr_q_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_HALTED);
    end
  end

  assign o_prog_ctr    = r_pc;
  assign o_instr_q     = r_instr_q;
  assign o_instr_pc    = r_instr_pc;
  assign o_op_addr     = r_instr_q[INSTR_W-1 -: 6];
  assign o_instr_valid = r_valid;
  assign o_running     = r_running;
  assign o_done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch against a behavioural model.
`default_nettype none

module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] start_addr = '0;
  logic       stall = 1'b0;
  logic       babs = 1'b0;
  logic       brel = 1'b0;
  logic [9:0] target = '0;
  logic       halt = 1'b0;
  logic [8:0] imem_data;
  logic [9:0] prog_ctr;
  logic [8:0] instr_q;
  logic [9:0] instr_pc;
  logic [5:0] op_addr;
  logic       instr_valid, running, done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0] pc;
    logic [8:0] iq;
    logic [9:0] ipc;
    logic       valid;
    logic       running;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: 0 idle, 1 run, 2 halted
  int         m_st = 0;
  logic [9:0] m_pc = '0;
  logic [8:0] m_iq = '0;
  logic [9:0] m_ipc = '0;
  logic       m_valid = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [8:0] mem(input logic [9:0] a);
    logic [9:0] t;
    t = a * 10'd5 + 10'd3;
    return t[8:0] ^ a[9:1];
  endfunction

  assign imem_data = mem(prog_ctr);

  instr_fetch #(.PC_W(10), .INSTR_W(9)) dut (
    .clk(clk), .rst(rst),
    .i_start(start), .i_start_addr(start_addr), .i_stall(stall),
    .i_branch_abs(babs), .i_branch_rel(brel), .i_target(target), .i_halt(halt),
    .i_imem_data(imem_data),
    .o_prog_ctr(prog_ctr), .o_instr_q(instr_q), .o_instr_pc(instr_pc),
    .o_op_addr(op_addr), .o_instr_valid(instr_valid),
    .o_running(running), .o_done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every edge the DUT presents a new state; compare against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("prog_ctr", 32'(prog_ctr), 32'(e.pc));
      chk("instr_valid", 32'(instr_valid), 32'(e.valid));
      chk("running", 32'(running), 32'(e.running));
      chk("done", 32'(done), 32'(e.done));
      chk("instr_q", 32'(instr_q), 32'(e.iq));
      chk("instr_pc", 32'(instr_pc), 32'(e.ipc));
      chk("op_addr", 32'(op_addr), 32'(e.iq[8:3]));
    end
  end

  task automatic model_step(input logic s, input logic [9:0] sa, input logic st,
                            input logic ba, input logic br, input logic [9:0] tg,
                            input logic h);
    exp_t e;
    if (m_st != 1) begin
      if (s) begin
        m_st = 1; m_pc = sa; m_valid = 1'b0;
      end
    end else if (!st) begin
      if (h && m_valid) begin
        m_st = 2; m_valid = 1'b0;
      end else if (ba && m_valid) begin
        m_pc = tg; m_valid = 1'b0;
      end else if (br && m_valid) begin
        m_pc = m_ipc + tg; m_valid = 1'b0;
      end else begin
        m_iq = mem(m_pc); m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 10'd1;
      end
    end
    e.pc = m_pc; e.iq = m_iq; e.ipc = m_ipc; e.valid = m_valid;
    e.running = (m_st == 1); e.done = (m_st == 2);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic [9:0] sa, input logic st,
                     input logic ba, input logic br, input logic [9:0] tg, input logic h);
    @(negedge clk);
    start = s; start_addr = sa; stall = st; babs = ba; brel = br; target = tg; halt = h;
    model_step(s, sa, st, ba, br, tg, h);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_prog_ctr"}, 32'(prog_ctr), 32'd0);
    chk({tag, "_instr_q"}, 32'(instr_q), 32'd0);
    chk({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Start at 0x010 and run sequentially until instr_pc 0x020 is live.
    cyc(1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    n = 0;
    while (!(m_valid && m_ipc == 10'h020) && n < 64) begin
      idle_cyc();
      n++;
    end
    chk("reach_pc20", 32'(m_ipc), 32'h020);
    // Relative branch by -4, then let the target arrive.
    cyc(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 10'h3FC, 1'b0);
    repeat (3) idle_cyc();
    // Stall with a pending absolute branch for three cycles, then release.
    repeat (3) cyc(1'b0, 10'h0, 1'b1, 1'b1, 1'b0, 10'h100, 1'b0);
    cyc(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 10'h100, 1'b0);
    repeat (3) idle_cyc();
    // Both branch kinds together: absolute wins.
    cyc(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 10'h055, 1'b0);
    repeat (2) idle_cyc();
    // Halt with a valid instruction, then halt while halted, then restart near wrap.
    cyc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b1);
    cyc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b1);
    idle_cyc();
    cyc(1'b1, 10'h3FE, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    // Halt/branch on a bubble is ignored.
    cyc(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1);
    repeat (3) idle_cyc();

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(15) == 0), 10'($urandom), ($urandom_range(3) == 0),
          ($urandom_range(7) == 0), ($urandom_range(7) == 0), 10'($urandom),
          ($urandom_range(31) == 0));
    end

    // Async reset mid-run, between edges.
    cyc(1'b1, 10'h2A0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    repeat (4) idle_cyc();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_st = 0; m_pc = '0; m_iq = '0; m_ipc = '0; m_valid = 1'b0;
    check_zero("async_rst");
    @(negedge clk);
    start = 1'b0; stall = 1'b0; babs = 1'b0; brel = 1'b0; halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0);
    repeat (5) idle_cyc();

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
